// File: rtl/rt_pixel_scan_if.sv
// rt_pixel_scan_if: frame request, stall/retire and coordinate bundle between CSR/RGU and the scanner
interface rt_pixel_scan_if #(
    parameter int DATA_W = 32,
    parameter int DIM_W  = 12
);
    logic              frame_start;
    logic [DIM_W-1:0]  image_width;
    logic [DIM_W-1:0]  image_height;
    logic              stall;
    logic              ray_valid;
    logic              start;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic              busy;
    logic              frame_done;

    modport master (
        output frame_start, image_width, image_height, stall, ray_valid,
        input  start, x, y, busy, frame_done
    );

    modport slave (
        input  frame_start, image_width, image_height, stall, ray_valid,
        output start, x, y, busy, frame_done
    );
endinterface

// File: rtl/rt_pixel_scan.sv
// rt_pixel_scan: raster-order fixed-point pixel sequencer feeding the RGU, with retire counting for frame completion
module rt_pixel_scan #(
    parameter int DATA_W = 32,
    parameter int FRAC   = 18,
    parameter int DIM_W  = 12
) (
    input logic            clk,
    input logic            resetn,
    rt_pixel_scan_if.slave sc
);
    localparam int CW = 2 * DIM_W;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} state_t;

    state_t            state_q;
    logic [DIM_W-1:0]  w_q, h_q, xcnt_q, ycnt_q;
    logic [CW-1:0]     retired_q, retired_d, total;
    logic [DATA_W-1:0] x_q, y_q;
    logic              start_q, busy_q, frame_done_q;
    logic              last_px, done_now;

    function automatic logic [DATA_W-1:0] fx(input logic [DIM_W-1:0] i);
        return DATA_W'(i) << FRAC;
    endfunction

    // frame size, last-pixel detection and retire bookkeeping
    always_comb begin
        total     = CW'(w_q) * CW'(h_q);
        last_px   = (xcnt_q == w_q - DIM_W'(1)) && (ycnt_q == h_q - DIM_W'(1));
        retired_d = retired_q + CW'(busy_q && sc.ray_valid && !sc.stall);
        done_now  = (state_q == DRAIN || (state_q == SCAN && !sc.stall && last_px)) && retired_d >= total;
    end

    // scan FSM: every output is a register updated here
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            w_q          <= '0;
            h_q          <= '0;
            xcnt_q       <= '0;
            ycnt_q       <= '0;
            retired_q    <= '0;
            x_q          <= '0;
            y_q          <= '0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            retired_q <= retired_d;
            case (state_q)
                IDLE: begin
                    frame_done_q <= sc.frame_start && (sc.image_width == '0 || sc.image_height == '0);
                    if (sc.frame_start && sc.image_width != '0 && sc.image_height != '0) begin
                        w_q     <= sc.image_width;
                        h_q     <= sc.image_height;
                        x_q     <= '0;
                        y_q     <= '0;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (!sc.stall) begin
                        if (last_px) begin
                            start_q <= 1'b0;
                            state_q <= DRAIN;
                        end else if (xcnt_q != w_q - DIM_W'(1)) begin
                            xcnt_q <= xcnt_q + DIM_W'(1);
                            x_q    <= fx(xcnt_q + DIM_W'(1));
                        end else begin
                            xcnt_q <= '0;
                            ycnt_q <= ycnt_q + DIM_W'(1);
                            x_q    <= '0;
                            y_q    <= fx(ycnt_q + DIM_W'(1));
                        end
                    end
                end
                DRAIN: begin
                end
                FIN: begin
                    frame_done_q <= 1'b0;
                    busy_q       <= 1'b0;
                    xcnt_q       <= '0;
                    ycnt_q       <= '0;
                    retired_q    <= '0;
                    x_q          <= '0;
                    y_q          <= '0;
                    state_q      <= IDLE;
                end
            endcase
            if (done_now) begin
                frame_done_q <= 1'b1;
                state_q      <= FIN;
            end
        end
    end

    assign sc.start      = start_q;
    assign sc.x          = x_q;
    assign sc.y          = y_q;
    assign sc.busy       = busy_q;
    assign sc.frame_done = frame_done_q;
endmodule

// File: doc/rt_pixel_scan.md
Name: rt_pixel_scan

Overview:
Frame-level pixel sequencer that drives the ray generation unit (RGU) input side. It walks (x, y) over a W×H image in raster order and presents each coordinate in Q(DATA_W-FRAC).FRAC fixed point with a start strobe. It obeys the shared pipeline stall and counts rays retired at the RGU output to detect frame completion. It sits between the control/CSR block (frame_start, dimensions) and the RGU.

Parameters:
DATA_W, 32, width of the x/y fixed-point coordinate outputs.
FRAC, 18, fractional bits; pixel index i is emitted as i << FRAC.
DIM_W, 12, width of the image_width and image_height integer inputs. DIM_W+FRAC must be <= DATA_W.

Ports:
clk  in  1  system clock
resetn  in  1  reset, synchronous, active-low
frame_start  in  1  one-cycle request to scan a frame; honoured only in IDLE
image_width  in  DIM_W  W in pixels; sampled when frame_start is accepted
image_height  in  DIM_W  H in pixels; sampled when frame_start is accepted
stall  in  1  shared pipeline stall; while 1, all scan state holds
ray_valid  in  1  RGU output valid; counted as retired only when stall=0
start  out  1  coordinate valid to the RGU
x  out  DATA_W  pixel column, fixed point
y  out  DATA_W  pixel row, fixed point
busy  out  1  high from frame acceptance until frame_done
frame_done  out  1  one-cycle pulse when the frame is complete

Behaviour:
- Single clock domain; resetn is synchronous and active-low. All outputs are registered.
- Reset values: start=0, x=0, y=0, busy=0, frame_done=0, state=IDLE, and all counters (xcnt, ycnt, issued, retired) = 0. Asserting resetn mid-frame abandons the frame with no frame_done.
- States:
  - IDLE
    - frame_start=1 with W>0 and H>0: latch W and H, go to SCAN. Next cycle: start=1, x=0, y=0, busy=1.
    - frame_start=1 with W=0 or H=0: frame_done=1 next cycle, stay IDLE, start never asserted.
    - frame_start is sampled regardless of stall.
  - SCAN
    - start=1; x = xcnt<<FRAC, y = ycnt<<FRAC (zero-extended).
    - Each cycle with stall=0, the current coordinate counts as accepted:
      - if xcnt<W-1: xcnt++;
      - else: xcnt=0, ycnt++.
    - When the accepted pixel is (W-1, H-1): start=0 next cycle, go to DRAIN.
    - With stall=1: start, x, y and the counters hold. No coordinate is skipped or duplicated.
  - DRAIN
    - start=0. retired increments on every ray_valid=1 && stall=0, in any state while busy.
    - When retired reaches W*H (2*DIM_W-bit compare): frame_done=1 for exactly one cycle, the following cycle busy=0, state returns to IDLE, and counters clear.
    - If the final retire happens while still in SCAN (not possible with latency >= 1, but tolerated), frame_done still requires all pixels to have been issued.
- frame_start while busy: ignored, with no effect on the current scan.
- ray_valid while in IDLE: ignored.
- Throughput: one coordinate per unstalled cycle. First coordinate appears 1 cycle after frame_start. Issue of a W*H frame takes exactly W*H unstalled SCAN cycles.

Test Plan:
- Reset: hold resetn=0 for 2 cycles -> start=0, x=0, y=0, busy=0, frame_done=0.
- W=4, H=2, no stall, frame_start at cycle 0:
  - start=1 during cycles 1-8.
  - x = 0x00000000, 0x00040000, 0x00080000, 0x000C0000, repeated twice.
  - y = 0x00000000 for cycles 1-4, then 0x00040000 for cycles 5-8.
  - start=0 at cycle 9.
  - ray_valid=1 during cycles 5-12 -> frame_done=1 only at cycle 13; busy=0 at cycle 14.
- Stall mid-scan: W=4, H=1, stall=1 for 3 cycles while x=0x00080000 -> x, y, start held for those cycles; the sequence resumes at 0x000C0000; exactly 4 coordinates accepted.
- Degenerate frames:
  - W=0, H=5 -> frame_done pulse next cycle, start never 1, busy stays 0.
  - W=1, H=1 -> a single start cycle with x=y=0; frame_done one cycle after the single unstalled ray_valid.
- ray_valid gated by stall: W=2, H=1, with ray_valid=1 and stall=1 on one retire cycle -> that retire is not counted, and frame_done waits for 2 unstalled retires.
- Abuse and abort:
  - frame_start re-pulsed at cycle 3 of a W=4, H=2 frame -> ignored; the coordinate sequence is unchanged.
  - resetn=0 mid-SCAN -> next cycle start=0, busy=0, no frame_done; a new frame_start then restarts from (0,0).
